// File: rtl/visitor_pkg.sv
// Shared definitions for the visitor counter: direction FSM encoding,
// serial operation selector and default sizing.
package visitor_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_COUNT = 99;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        A_FIRST    = 2'd1,
        B_FIRST    = 2'd2,
        WAIT_CLEAR = 2'd3
    } dir_state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/visitor_seq_ctrl_if.sv
// Sensor inputs and counter status outputs of the visitor counter.
interface visitor_seq_ctrl_if #(
    parameter int WIDTH = visitor_pkg::DEF_WIDTH
);
    logic             sensor_a;
    logic             sensor_b;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             entry_pulse;
    logic             exit_pulse;
    logic             full;
    logic             empty;

    // No valid/ready pairs here: sensors are level inputs sampled every clock,
    // entry_pulse/exit_pulse are single-cycle strobes with no back-pressure,
    // and count/full/empty are always valid.
    modport master (
        output sensor_a, sensor_b,
        input  count, busy, entry_pulse, exit_pulse, full, empty
    );

    modport slave (
        input  sensor_a, sensor_b,
        output count, busy, entry_pulse, exit_pulse, full, empty
    );
endinterface

// File: rtl/addsub_bit_cell.sv
// One-bit half-adder / half-subtractor; mode selects carry or borrow out.
module addsub_bit_cell
    import visitor_pkg::*;
(
    input  logic a,
    input  logic cin,
    input  op_t  mode,
    output logic s,
    output logic cout
);
    assign s    = a ^ cin;
    assign cout = (mode == OP_SUB) ? (~a & cin) : (a & cin);
endmodule

// File: rtl/visitor_seq_ctrl.sv
// Two-beam direction detector feeding a bit-serial saturating up/down
// visitor counter. count only changes once the full serial result is ready.
module visitor_seq_ctrl
    import visitor_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_COUNT = DEF_MAX_COUNT
) (
    input  logic               clk,
    input  logic               rst,
    visitor_seq_ctrl_if.slave  bus,
    output dir_state_t         state_dbg
);
    localparam int              IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_COUNT);

    dir_state_t       state, state_nxt;
    logic             entry_evt, exit_evt;
    logic             accept_entry, accept_exit;
    logic [WIDTH-1:0] count_q, work_q, shifted;
    logic [IDXW-1:0]  bit_idx_q;
    logic             carry_q, carry_nxt, res_bit;
    logic             busy_q, entry_q, exit_q;
    op_t              op_q;

    always_comb begin
        state_nxt = state;
        entry_evt = 1'b0;
        exit_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sensor_a && bus.sensor_b)       state_nxt = WAIT_CLEAR;
                else if (bus.sensor_a)                  state_nxt = A_FIRST;
                else if (bus.sensor_b)                  state_nxt = B_FIRST;
            end
            A_FIRST: begin
                if (bus.sensor_b) begin
                    entry_evt = 1'b1;
                    state_nxt = WAIT_CLEAR;
                end else if (!bus.sensor_a)             state_nxt = IDLE;
            end
            B_FIRST: begin
                if (bus.sensor_a) begin
                    exit_evt  = 1'b1;
                    state_nxt = WAIT_CLEAR;
                end else if (!bus.sensor_b)             state_nxt = IDLE;
            end
            WAIT_CLEAR: begin
                // Holding here until busy drops is what keeps events from overlapping.
                if (!bus.sensor_a && !bus.sensor_b && !busy_q) state_nxt = IDLE;
            end
            default:                                    state_nxt = IDLE;
        endcase
    end

    assign accept_entry = entry_evt && (count_q < MAXC);
    assign accept_exit  = exit_evt && (count_q != '0);

    addsub_bit_cell u_cell (
        .a    (work_q[0]),
        .cin  (carry_q),
        .mode (op_q),
        .s    (res_bit),
        .cout (carry_nxt)
    );

    // Result bits enter at the MSB so after WIDTH shifts they sit in place.
    assign shifted = {res_bit, work_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count_q   <= '0;
            work_q    <= '0;
            bit_idx_q <= '0;
            carry_q   <= 1'b0;
            busy_q    <= 1'b0;
            entry_q   <= 1'b0;
            exit_q    <= 1'b0;
            op_q      <= OP_ADD;
        end else begin
            state   <= state_nxt;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
            if (busy_q) begin
                work_q    <= shifted;
                carry_q   <= carry_nxt;
                bit_idx_q <= bit_idx_q + IDXW'(1);
                if (bit_idx_q == IDXW'(WIDTH - 1)) begin
                    count_q   <= shifted;
                    busy_q    <= 1'b0;
                    bit_idx_q <= '0;
                    carry_q   <= 1'b0;
                end
            end else if (accept_entry || accept_exit) begin
                busy_q    <= 1'b1;
                work_q    <= count_q;
                carry_q   <= 1'b1;
                bit_idx_q <= '0;
                op_q      <= accept_exit ? OP_SUB : OP_ADD;
                entry_q   <= accept_entry;
                exit_q    <= accept_exit;
            end
        end
    end

    assign bus.count       = count_q;
    assign bus.busy        = busy_q;
    assign bus.entry_pulse = entry_q;
    assign bus.exit_pulse  = exit_q;
    assign bus.full        = (count_q == MAXC);
    assign bus.empty       = (count_q == '0);
    assign state_dbg       = state;
endmodule

// File: tb/tb_visitor_seq_ctrl.sv
// Bench for visitor_seq_ctrl: scenario tasks with inline checks plus a
// count-change scoreboard fed by a reference visitor model.
module tb_visitor_seq_ctrl;
    import visitor_pkg::*;

    localparam int W    = 8;
    localparam int MAXC = 99;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    dir_state_t state_dbg;

    visitor_seq_ctrl_if #(.WIDTH(W)) bus ();

    visitor_seq_ctrl #(.WIDTH(W), .MAX_COUNT(MAXC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int           tests = 0;
    int           fails = 0;
    int           model_count = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] prev_count = '0;
    logic         rst_d = 1'b0;

    // Scoreboard: every visible count change must match the next queued value.
    always @(negedge clk) begin
        if (rst || rst_d) begin
            prev_count = bus.count;
        end else if (bus.count !== prev_count) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_change: count=%0d prev=%0d expected no change", bus.count, prev_count);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (bus.count !== e) begin
                    fails++;
                    $display("FAIL sb_count: got %0d expected %0d", bus.count, e);
                end
            end
            prev_count = bus.count;
        end
        rst_d = rst;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic a, input logic b);
        bus.sensor_a = a;
        bus.sensor_b = b;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0);
        step(2);
        model_count = 0;
        exp_q.delete();
        rst = 1'b0;
    endtask

    // Drive up to the cycle where the direction is detected; the model updates here.
    task automatic seq_entry(input int a_cycles);
        drive(1'b1, 1'b0);
        step(a_cycles);
        drive(1'b1, 1'b1);
        if (model_count < MAXC) begin
            model_count++;
            exp_q.push_back(W'(model_count));
        end
    endtask

    task automatic seq_exit(input int b_cycles);
        drive(1'b0, 1'b1);
        step(b_cycles);
        drive(1'b1, 1'b1);
        if (model_count > 0) begin
            model_count--;
            exp_q.push_back(W'(model_count));
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((bus.busy || state_dbg != IDLE) && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.busy || state_dbg != IDLE) begin
            fails++;
            $display("FAIL %s idle_timeout: busy=%0b state=%0d expected busy=0 state=IDLE", name, bus.busy, state_dbg);
        end
    endtask

    task automatic fast_entry();
        seq_entry(1);
        step(1);
        drive(1'b0, 1'b0);
        wait_idle("fast_entry");
    endtask

    task automatic fast_exit();
        seq_exit(1);
        step(1);
        drive(1'b0, 1'b0);
        wait_idle("fast_exit");
    endtask

    // Watch 12 cycles after the detection edge; k counts cycles after it.
    task automatic observe(input bit accept, input bit is_entry, input string name);
        int ent_n = 0, ext_n = 0, busy_n = 0, ent_k = 0, ext_k = 0, busy_k = 0, chg_k = 0;
        int exp_ent, exp_ext;
        logic [W-1:0] c0;
        c0 = bus.count;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.entry_pulse) begin ent_n++; if (ent_k == 0) ent_k = k; end
            if (bus.exit_pulse)  begin ext_n++; if (ext_k == 0) ext_k = k; end
            if (bus.busy)        begin busy_n++; if (busy_k == 0) busy_k = k; end
            if (bus.count !== c0 && chg_k == 0) chg_k = k;
            if (k == 1) begin
                tests++;
                if (state_dbg !== WAIT_CLEAR) begin
                    fails++;
                    $display("FAIL %s state_after_detect: got %0d expected %0d", name, state_dbg, WAIT_CLEAR);
                end
                drive(1'b0, 1'b0);
            end
        end
        exp_ent = (accept && is_entry) ? 1 : 0;
        exp_ext = (accept && !is_entry) ? 1 : 0;
        tests++;
        if (ent_n != exp_ent || ext_n != exp_ext || ent_k != exp_ent || ext_k != exp_ext) begin
            fails++;
            $display("FAIL %s pulses: entry n=%0d k=%0d exit n=%0d k=%0d expected entry %0d exit %0d at k=1",
                     name, ent_n, ent_k, ext_n, ext_k, exp_ent, exp_ext);
        end
        tests++;
        if (busy_n != (accept ? W : 0) || busy_k != (accept ? 1 : 0)) begin
            fails++;
            $display("FAIL %s busy: cycles=%0d first=%0d expected cycles=%0d first=%0d",
                     name, busy_n, busy_k, accept ? W : 0, accept ? 1 : 0);
        end
        tests++;
        if (chg_k != (accept ? W + 1 : 0)) begin
            fails++;
            $display("FAIL %s count_latency: got %0d expected %0d", name, chg_k, accept ? W + 1 : 0);
        end
        tests++;
        if (bus.count !== W'(model_count) || bus.full !== (model_count == MAXC) ||
            bus.empty !== (model_count == 0) || state_dbg !== IDLE) begin
            fails++;
            $display("FAIL %s final: count=%0d full=%0b empty=%0b state=%0d expected count=%0d full=%0b empty=%0b state=0",
                     name, bus.count, bus.full, bus.empty, state_dbg, model_count,
                     model_count == MAXC, model_count == 0);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if (bus.count !== '0 || bus.busy !== 1'b0 || bus.entry_pulse !== 1'b0 || bus.exit_pulse !== 1'b0 ||
            bus.empty !== 1'b1 || bus.full !== 1'b0 || state_dbg !== IDLE) begin
            fails++;
            $display("FAIL reset_state: count=%0d busy=%0b ep=%0b xp=%0b empty=%0b full=%0b state=%0d expected 0 0 0 0 1 0 0",
                     bus.count, bus.busy, bus.entry_pulse, bus.exit_pulse, bus.empty, bus.full, state_dbg);
        end
    endtask

    task automatic test_entry();
        seq_entry(2);
        observe(1'b1, 1'b1, "entry_from_zero");
    endtask

    task automatic test_exit();
        while (model_count < 5) fast_entry();
        seq_exit(1);
        observe(1'b1, 1'b0, "exit_from_five");
    endtask

    task automatic test_abort();
        int pulses = 0;
        logic [1:0] st;
        drive(1'b1, 1'b0);
        step(2);
        st[0] = (state_dbg == A_FIRST);
        pulses += int'(bus.entry_pulse) + int'(bus.exit_pulse) + int'(bus.busy);
        drive(1'b0, 1'b0);
        step(1);
        st[1] = (state_dbg == IDLE);
        tests++;
        if (st !== 2'b11) begin
            fails++;
            $display("FAIL abort_a_only: state checks=%b expected 11", st);
        end
        drive(1'b0, 1'b1);
        step(2);
        st[0] = (state_dbg == B_FIRST);
        pulses += int'(bus.entry_pulse) + int'(bus.exit_pulse) + int'(bus.busy);
        drive(1'b0, 1'b0);
        step(2);
        st[1] = (state_dbg == IDLE);
        pulses += int'(bus.entry_pulse) + int'(bus.exit_pulse) + int'(bus.busy);
        tests++;
        if (st !== 2'b11 || pulses != 0 || bus.count !== W'(model_count)) begin
            fails++;
            $display("FAIL abort_b_only: state checks=%b activity=%0d count=%0d expected 11 0 %0d",
                     st, pulses, bus.count, model_count);
        end
    endtask

    task automatic test_simultaneous();
        int act = 0;
        logic [1:0] st;
        drive(1'b1, 1'b1);
        step(1);
        st[0] = (state_dbg == WAIT_CLEAR);
        for (int i = 0; i < 3; i++) begin
            act += int'(bus.entry_pulse) + int'(bus.exit_pulse) + int'(bus.busy);
            step(1);
        end
        drive(1'b0, 1'b0);
        step(1);
        st[1] = (state_dbg == IDLE);
        tests++;
        if (st !== 2'b11 || act != 0 || bus.count !== W'(model_count)) begin
            fails++;
            $display("FAIL simultaneous: state checks=%b activity=%0d count=%0d expected 11 0 %0d",
                     st, act, bus.count, model_count);
        end
    endtask

    task automatic test_busy_hold();
        logic [2:0] st;
        seq_entry(1);
        step(1);
        drive(1'b1, 1'b0);
        step(3);
        st[0] = (state_dbg == WAIT_CLEAR) && bus.busy;
        drive(1'b0, 1'b0);
        step(1);
        st[1] = (state_dbg == WAIT_CLEAR) && bus.busy;
        drive(1'b0, 1'b1);
        step(1);
        st[2] = (state_dbg == WAIT_CLEAR);
        drive(1'b0, 1'b0);
        wait_idle("busy_hold");
        tests++;
        if (st !== 3'b111 || bus.count !== W'(model_count)) begin
            fails++;
            $display("FAIL busy_hold: state checks=%b count=%0d expected 111 %0d", st, bus.count, model_count);
        end
    endtask

    task automatic test_full();
        while (model_count < MAXC) fast_entry();
        tests++;
        if (bus.full !== 1'b1 || bus.count !== W'(MAXC)) begin
            fails++;
            $display("FAIL full_flag: full=%0b count=%0d expected 1 %0d", bus.full, bus.count, MAXC);
        end
        seq_entry(1);
        observe(1'b0, 1'b1, "entry_at_full");
    endtask

    task automatic test_back_to_back();
        seq_exit(1);
        observe(1'b1, 1'b0, "exit_from_full");
        seq_entry($urandom_range(1, 3));
        observe(1'b1, 1'b1, "entry_back_to_full");
        fast_exit();
        fast_exit();
    endtask

    task automatic test_empty();
        apply_reset();
        seq_exit(1);
        observe(1'b0, 1'b0, "exit_at_empty");
        seq_entry(1);
        step(1);
        drive(1'b0, 1'b0);
        wait_idle("empty_then_entry");
        fast_exit();
        tests++;
        if (bus.empty !== 1'b1 || bus.count !== '0) begin
            fails++;
            $display("FAIL empty_flag: empty=%0b count=%0d expected 1 0", bus.empty, bus.count);
        end
    endtask

    task automatic test_reset_mid_op();
        int bad = 0;
        while (model_count < 15) fast_entry();
        seq_entry(1);
        step(1);
        drive(1'b0, 1'b0);
        step(2);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_busy_precheck: busy=%0b expected 1", bus.busy);
        end
        rst = 1'b1;
        step(1);
        model_count = 0;
        exp_q.delete();
        tests++;
        if (bus.count !== '0 || bus.busy !== 1'b0 || bus.entry_pulse !== 1'b0 || bus.empty !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_op: count=%0d busy=%0b ep=%0b empty=%0b expected 0 0 0 1",
                     bus.count, bus.busy, bus.entry_pulse, bus.empty);
        end
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (bus.count !== '0 || bus.busy || bus.entry_pulse || bus.exit_pulse) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_mid_op_quiet: %0d cycles with activity expected 0", bad);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0);
        step(1);
        test_reset();
        test_entry();
        test_exit();
        test_abort();
        test_simultaneous();
        test_busy_hold();
        test_full();
        test_back_to_back();
        test_empty();
        test_reset_mid_op();
        step(2);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d expected counts never seen, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
